hit_scorer: RTL and testbench
=============================

HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 Parameter TARGET_POS, default 3'd7: light position that counts as a hit.
REQ-002 Parameter MAX_MISSES, default 3: number of misses that ends the game (range 1..3).
REQ-003 Parameter SCORE_MAX, default 9: score that wins the game (range 1..9).
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; it is sampled on the rising edge of clk.
REQ-006 pos  in  3  current light position from the light counter.
REQ-007 pos_step  in  1  one-cycle pulse in the clk domain; pos takes a new value on the cycle after this pulse.
REQ-008 btn_n  in  1  debounced button level, active-low (0 = pressed).
REQ-009 score  out  4  BCD score 0..SCORE_MAX; it drives the 7-segment decoder.
REQ-010 misses  out  2  miss count 0..MAX_MISSES.
REQ-011 playing  out  1  high in the PLAY state.
REQ-012 game_over  out  1  high in the OVER state.
REQ-013 win  out  1  high in the OVER state when the game ended with score == SCORE_MAX.
REQ-014 hit_pulse, miss_pulse  out  1 each  one-cycle event strobes.

Function
REQ-015 A press event is a 1->0 transition of btn_n, taken from a registered copy of btn_n; the event is valid in the cycle where prev=1 and cur=0.
REQ-016 The FSM states are IDLE, PLAY and OVER; reset enters IDLE.
REQ-017 IDLE: a press event clears score, misses and win and moves to PLAY; that press is not scored.
REQ-018 Target window: it opens on the cycle pos == TARGET_POS and closes on the cycle after pos leaves TARGET_POS; one window exists per light lap.
REQ-019 PLAY: a press with pos == TARGET_POS in an open window that is not yet hit increments score, pulses hit_pulse and marks the window as hit.
REQ-020 PLAY: a press with pos == TARGET_POS in an already-hit window is ignored; it does not count as a hit or a miss.
REQ-021 PLAY: a press with pos != TARGET_POS increments misses and pulses miss_pulse.
REQ-022 A window that closes without a hit causes no penalty.
REQ-023 A press and pos_step in the same cycle: the press is judged against the current (pre-step) pos.
REQ-024 Latency: score, misses and the pulses update on the clock edge after the press-detect cycle; the FSM transition happens on that same edge.
REQ-025 If score reaches SCORE_MAX: set win and go to OVER; score saturates and never wraps.
REQ-026 If misses reaches MAX_MISSES: clear win and go to OVER; misses saturates.
REQ-027 OVER: score, misses and win are frozen; a press event moves to IDLE, and score stays displayed until the next IDLE->PLAY transition.
REQ-028 The hit/miss pulses are never both high in one cycle, and neither is asserted outside PLAY.

Reset
REQ-029 When reset == 0 at a clock edge, the block goes to state IDLE and sets score=0, misses=0, win=0, playing=0, game_over=0, both pulses 0, and the hit flag clear.
REQ-030 The registered copy of btn_n resets to 0, so a button held through reset produces no press event.
REQ-031 Reset asserted mid-game takes priority over any press event in the same cycle.

Structure
REQ-032 A shared package holds the state enum (IDLE/PLAY/OVER) and the constants SCORE_W=4 and MISS_W=2.
REQ-033 The press edge detector is a sub-module named press_edge with ports clk, reset, btn_n and press.
REQ-034 The FSM, the score/miss counters and the window-hit flag live in hit_scorer.

Verification
REQ-035 Scenario: reset, then press with pos=0 -> playing=1 after 1 cycle, with score=0 and misses=0.
REQ-036 Scenario: in PLAY with pos=7, press -> hit_pulse for 1 cycle and score=1; a second press while pos is still 7 -> score stays 1 and there is no miss_pulse.
REQ-037 Scenario: in PLAY, press 3 times with pos=2 -> misses counts 1, 2, 3, then game_over=1 and win=0; further presses while in OVER do not change the frozen outputs.
REQ-038 Scenario: 9 hits on consecutive laps -> score reaches 9, win=1 and game_over=1; the next press -> IDLE with score still 9, and the press after that -> PLAY with score=0.
REQ-039 Scenario: a press coincides with pos_step while pos=7 (stepping to 0) -> counts as a hit.
REQ-040 Scenario: btn_n held at 0 through reset release -> no press event; reset=0 asserted during PLAY with score=5 -> IDLE and score=0 on the next edge.

Source files
------------

// File: rtl/hit_scorer_pkg.sv
// hit_scorer_pkg: shared FSM state type and counter widths for the hit scorer
package hit_scorer_pkg;
    localparam int SCORE_W = 4;
    localparam int MISS_W = 2;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
endpackage

// File: rtl/hit_scorer_press_edge.sv
// press_edge: turns the debounced active-low button level into a one-cycle press event
module press_edge
    import hit_scorer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    logic prev;
    // prev clears to 0 so a button held through reset never looks like a fresh press
    always_ff @(posedge clk)
        prev <= !reset ? 1'b0 : btn_n;
    assign press = prev & ~btn_n;
endmodule

// File: rtl/hit_scorer.sv
// hit_scorer: game FSM, BCD score and miss counters, and per-lap target window hit flag
module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter logic [2:0] TARGET_POS = 3'd7,
    parameter int         MAX_MISSES = 3,
    parameter int         SCORE_MAX  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         pos,
    input  logic               pos_step,
    input  logic               btn_n,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               playing,
    output logic               game_over,
    output logic               win,
    output logic               hit_pulse,
    output logic               miss_pulse
);
    localparam logic [SCORE_W-1:0] S_MAX = SCORE_W'(SCORE_MAX);
    localparam logic [MISS_W-1:0]  M_MAX = MISS_W'(MAX_MISSES);
    state_t state, state_nx;
    logic press, at_target, hit_flag, hit, miss;
    press_edge u_press (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_n),
        .press(press)
    );
    assign at_target = pos == TARGET_POS;
    assign hit = state == PLAY && press && at_target && !hit_flag;
    assign miss = state == PLAY && press && !at_target;
    assign playing = state == PLAY;
    assign game_over = state == OVER;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = press ? PLAY : IDLE;
            PLAY: state_nx = (hit && score + 1'b1 == S_MAX) || (miss && misses + 1'b1 == M_MAX) ? OVER : PLAY;
            OVER: state_nx = press ? IDLE : OVER;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            score      <= '0;
            misses     <= '0;
            win        <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            hit_flag   <= 1'b0;
        end else begin
            state      <= state_nx;
            hit_pulse  <= hit;
            miss_pulse <= miss;
            // the window ends when the light leaves the target or steps away from it
            hit_flag   <= hit ? !pos_step : hit_flag && at_target && !pos_step;
            if (state == IDLE && press) begin
                score  <= '0;
                misses <= '0;
                win    <= 1'b0;
            end
            if (hit)
                score <= score + 1'b1;
            if (miss)
                misses <= misses + 1'b1;
            if (state == PLAY && state_nx == OVER)
                win <= hit;
        end
    end
endmodule

// File: tb/tb_hit_scorer.sv
// tb_hit_scorer: directed scenarios plus random play, checked against a lap-based game model via a scoreboard
module tb_hit_scorer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [2:0] pos = 3'd0;
    logic pos_step = 1'b0;
    logic btn_n = 1'b1;
    logic [3:0] score;
    logic [1:0] misses;
    logic playing, game_over, win, hit_pulse, miss_pulse;
    int checks = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
    int m_state = M_IDLE, m_score = 0, m_misses = 0, win_id = 0, hit_win = -1;
    bit m_win = 0, m_hp = 0, m_mp = 0, m_prev = 0;
    logic btn_lvl;

    hit_scorer dut (
        .clk(clk), .reset(reset), .pos(pos), .pos_step(pos_step), .btn_n(btn_n),
        .score(score), .misses(misses), .playing(playing), .game_over(game_over),
        .win(win), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit press;
        if (!reset) begin
            m_state = M_IDLE; m_score = 0; m_misses = 0; m_win = 0;
            m_hp = 0; m_mp = 0; m_prev = 0; hit_win = -1;
            return;
        end
        press = m_prev && !btn_n;
        m_hp = 0; m_mp = 0;
        if (press) begin
            if (m_state == M_IDLE) begin
                m_score = 0; m_misses = 0; m_win = 0; m_state = M_PLAY;
            end else if (m_state == M_OVER) begin
                m_state = M_IDLE;
            end else if (pos == 3'd7) begin
                if (hit_win != win_id) begin
                    m_score++; m_hp = 1; hit_win = win_id;
                    if (m_score == 9) begin m_win = 1; m_state = M_OVER; end
                end
            end else begin
                m_misses++; m_mp = 1;
                if (m_misses == 3) begin m_win = 0; m_state = M_OVER; end
            end
        end
        m_prev = btn_n;
    endtask

    task automatic tick(input logic b, input logic s, input logic r);
        logic [2:0] np;
        btn_n = b; pos_step = s; reset = r;
        @(posedge clk); #1;
        model_edge();
        exp_q.push_back({4'(m_score), 2'(m_misses), m_state == M_PLAY, m_state == M_OVER, m_win, m_hp, m_mp});
        if (s) begin
            np = pos + 3'd1;
            if (np == 3'd7) win_id++;
            pos = np;
        end
    endtask

    task automatic press_btn(input logic s);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, s, 1'b1);
    endtask

    task automatic step_to(input logic [2:0] p);
        for (int i = 0; i < 8 && pos != p; i++) tick(1'b1, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        logic [10:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {score, misses, playing, game_over, win, hit_pulse, miss_pulse};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got score=%0d misses=%0d play=%b over=%b win=%b hp=%b mp=%b expected score=%0d misses=%0d play=%b over=%b win=%b hp=%b mp=%b",
                    $time, a[10:7], a[6:5], a[4], a[3], a[2], a[1], a[0], e[10:7], e[6:5], e[4], e[3], e[2], e[1], e[0]);
            end
            checks++;
            if (hit_pulse && miss_pulse) begin
                failures++;
                $display("FAIL pulse_excl t=%0t hit_pulse=%b miss_pulse=%b required not both high", $time, hit_pulse, miss_pulse);
            end
        end
    end

    initial begin
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b1);
        press_btn(1'b0);
        tick(1'b1, 1'b0, 1'b1);
        step_to(3'd7);
        press_btn(1'b0);
        press_btn(1'b0);
        tick(1'b1, 1'b0, 1'b1);
        step_to(3'd2);
        repeat (3) press_btn(1'b0);
        repeat (2) tick(1'b1, 1'b0, 1'b1);
        press_btn(1'b0);
        press_btn(1'b0);
        for (int k = 0; k < 9; k++) begin
            step_to(3'd7);
            press_btn(1'b0);
            tick(1'b1, 1'b1, 1'b1);
        end
        tick(1'b1, 1'b0, 1'b1);
        press_btn(1'b0);
        press_btn(1'b0);
        tick(1'b1, 1'b0, 1'b1);
        step_to(3'd7);
        press_btn(1'b1);
        for (int k = 0; k < 4; k++) begin
            step_to(3'd7);
            press_btn(1'b0);
            tick(1'b1, 1'b1, 1'b1);
        end
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        btn_lvl = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if (!btn_lvl) btn_lvl = $urandom_range(0, 1) == 0;
            else btn_lvl = !(pos == 3'd7 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 9) == 0);
            tick(btn_lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
        end
        tick(1'b1, 1'b0, 1'b1);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
